// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Round-robin arbiter that shares one registered data-memory port among four
// cores. Each access is a req/gnt handshake; reads return one byte to the
// winning core with a one-cycle rd_valid pulse, writes store two bytes.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req, we_req       per-core request and op (1=write 16-bit, 0=read byte)
//   addr_in           core i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata_in          core i write data at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
//   gnt, rd_valid     one-hot single-cycle pulses to the cores
//   rd_data           read byte, qualified by rd_valid
//   busy              high whenever the arbiter is not idle
//   mem_we, mem_addr, mem_wdata, mem_rdata   memory port
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                req,
  input  logic [3:0]                we_req,
  input  logic [4*ADDR_WIDTH-1:0]   addr_in,
  input  logic [8*DATA_WIDTH-1:0]   wdata_in,
  output logic [3:0]                gnt,
  output logic [3:0]                rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      busy,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [2*DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int unsigned NCORE = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned WD_W  = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cur;

  logic                  found_c;
  logic [IDX_W-1:0]      win_c;
  logic                  win_we_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic [WD_W-1:0]       win_wdata_c;

  // Round-robin scan starting at ptr; first requester found wins.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int k = 0; k < NCORE; k++) begin
      if (!found_c && req[IDX_W'(ptr + IDX_W'(k))]) begin
        found_c = 1'b1;
        win_c   = IDX_W'(ptr + IDX_W'(k));
      end
    end
  end

  // Select the winner's op, address and write data.
  always_comb begin
    win_we_c    = 1'b0;
    win_addr_c  = '0;
    win_wdata_c = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (win_c == IDX_W'(i)) begin
        win_we_c    = we_req[i];
        win_addr_c  = addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata_c = wdata_in[i*WD_W +: WD_W];
      end
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cur       <= '0;
      gnt       <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Pulses default low; each lasts exactly one cycle.
      gnt      <= '0;
      rd_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (found_c) begin
            gnt       <= NCORE'(1) << win_c;
            mem_we    <= win_we_c;
            mem_addr  <= win_addr_c;
            mem_wdata <= win_wdata_c;
            cur       <= win_c;
            ptr       <= IDX_W'(win_c + IDX_W'(1));
            busy      <= 1'b1;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          // Command is on the port this cycle; write enable never outlives it.
          mem_we <= 1'b0;
          if (mem_we) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          rd_data  <= mem_rdata;
          rd_valid <= NCORE'(1) << cur;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-schedule model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we_req;
  logic [31:0] addr_in;
  logic [63:0] wdata_in;
  logic [3:0]  gnt;
  logic [3:0]  rd_valid;
  logic [7:0]  rd_data;
  logic        busy;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  c_addr [4];
  logic [15:0] c_wd   [4];

  always #5 clk = ~clk;

  always_comb begin
    addr_in  = '0;
    wdata_in = '0;
    for (int i = 0; i < 4; i++) begin
      addr_in[i*8 +: 8]   = c_addr[i];
      wdata_in[i*16 +: 16] = c_wd[i];
    end
  end

  mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req(req), .we_req(we_req),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory device: registered read, two-byte write with address wrap.
  logic [7:0] mem_arr [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i + 2);
    end else if (mem_we) begin
      mem_arr[mem_addr]              <= mem_wdata[7:0];
      mem_arr[8'(mem_addr + 8'd1)]   <= mem_wdata[15:8];
    end
    mem_rdata <= mem_arr[mem_addr];
  end

  // Reference model: each accepted request schedules its visible effects
  // into future cycles (grant/command at +1, read return at +3).
  typedef struct packed {
    logic [31:0] tag;
    logic        clr;
    logic [3:0]  gnt;
    logic [3:0]  rdv;
    logic        busy;
    logic        we;
    logic        set_addr;
    logic        set_rd;
    logic [7:0]  addr;
    logic [7:0]  rd;
    logic [15:0] wdata;
  } slot_t;

  slot_t      slot [8];
  logic [7:0] ref_mem [256];
  int         cyc = 0;
  int         free_at = 0;
  int         m_ptr = 0;
  bit         model_on = 1'b0;

  task automatic prep(input int x);
    if (slot[x % 8].tag != 32'(x)) begin
      slot[x % 8]     = '0;
      slot[x % 8].tag = 32'(x);
    end
  endtask

  always @(posedge clk) begin : model
    int w;
    int a;
    if (rst) begin
      for (int s = 0; s < 8; s++) begin
        slot[s]     = '0;
        slot[s].tag = '1;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 2);
      m_ptr    = 0;
      free_at  = cyc + 1;
      model_on = 1'b1;
      prep(cyc + 1);
      slot[(cyc + 1) % 8].clr = 1'b1;
    end else if (model_on && cyc >= free_at && req != 4'b0) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      a = int'(c_addr[w]);
      prep(cyc + 1);
      slot[(cyc + 1) % 8].gnt      = 4'(1 << w);
      slot[(cyc + 1) % 8].busy     = 1'b1;
      slot[(cyc + 1) % 8].we       = we_req[w];
      slot[(cyc + 1) % 8].set_addr = 1'b1;
      slot[(cyc + 1) % 8].addr     = 8'(a);
      slot[(cyc + 1) % 8].wdata    = c_wd[w];
      m_ptr = (w + 1) % 4;
      if (we_req[w]) begin
        ref_mem[a]             = c_wd[w][7:0];
        ref_mem[(a + 1) % 256] = c_wd[w][15:8];
        free_at = cyc + 2;
      end else begin
        prep(cyc + 2);
        slot[(cyc + 2) % 8].busy = 1'b1;
        prep(cyc + 3);
        slot[(cyc + 3) % 8].rdv    = 4'(1 << w);
        slot[(cyc + 3) % 8].set_rd = 1'b1;
        slot[(cyc + 3) % 8].rd     = ref_mem[a];
        free_at = cyc + 3;
      end
    end
    cyc++;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0]  h_addr, h_rd;
  logic [15:0] h_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    slot_t s;
    if (!model_on) return;
    s = slot[cyc % 8];
    if (s.tag != 32'(cyc)) s = '0;
    if (s.clr) begin
      h_addr = '0; h_wdata = '0; h_rd = '0;
    end
    if (s.set_addr) begin
      h_addr = s.addr; h_wdata = s.wdata;
    end
    if (s.set_rd) h_rd = s.rd;
    check("m_gnt",      32'(gnt),       32'(s.gnt));
    check("m_rd_valid", 32'(rd_valid),  32'(s.rdv));
    check("m_busy",     32'(busy),      32'(s.busy));
    check("m_mem_we",   32'(mem_we),    32'(s.we));
    check("m_mem_addr", 32'(mem_addr),  32'(h_addr));
    check("m_mem_wdata",32'(mem_wdata), 32'(h_wdata));
    check("m_rd_data",  32'(rd_data),   32'(h_rd));
    check("gnt_onehot", 32'($onehot0(gnt)), 32'(1));
    check("rdv_onehot", 32'($onehot0(rd_valid)), 32'(1));
  endtask

  task automatic step();
    @(negedge clk);
    compare();
  endtask

  int order [6] = '{0, 1, 2, 3, 0, 3};
  int waits [4];

  initial begin
    rst = 1'b1; req = '0; we_req = '0;
    for (int i = 0; i < 4; i++) begin c_addr[i] = '0; c_wd[i] = '0; end
    step(); step();
    check("rst_gnt",  32'(gnt), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_we",   32'(mem_we), 32'(0));
    check("rst_rd",   32'(rd_data), 32'(0));
    rst = 1'b0;
    step();

    // Core2 reads address 8 (initial content 10).
    c_addr[2] = 8'd8; we_req[2] = 1'b0; req = 4'b0100;
    step();
    check("rd_gnt",   32'(gnt), 32'h4);
    check("rd_addr",  32'(mem_addr), 32'd8);
    check("rd_we",    32'(mem_we), 32'd0);
    req = '0;
    step();
    step();
    check("rd_valid", 32'(rd_valid), 32'h4);
    check("rd_data",  32'(rd_data), 32'd10);
    step();

    // Core0 writes 0x0302 at 4, then core1 reads 5.
    c_addr[0] = 8'd4; c_wd[0] = 16'h0302; we_req[0] = 1'b1; req = 4'b0001;
    step();
    check("wr_gnt",   32'(gnt), 32'h1);
    check("wr_we",    32'(mem_we), 32'd1);
    check("wr_addr",  32'(mem_addr), 32'd4);
    check("wr_wdata", 32'(mem_wdata), 32'h0302);
    req = '0;
    step();
    check("wr_we_drop", 32'(mem_we), 32'd0);
    c_addr[1] = 8'd5; we_req[1] = 1'b0; req = 4'b0010;
    step();
    check("rb_gnt", 32'(gnt), 32'h2);
    req = '0;
    step(); step();
    check("rb_valid", 32'(rd_valid), 32'h2);
    check("rb_data",  32'(rd_data), 32'd3);
    check("model_mem4", 32'(ref_mem[4]), 32'd2);
    check("model_mem5", 32'(ref_mem[5]), 32'd3);
    step();

    // All four cores write continuously, then the 3->0 pointer wrap.
    rst = 1'b1; step(); rst = 1'b0; step();
    for (int i = 0; i < 4; i++) begin
      c_addr[i] = 8'($urandom); c_wd[i] = 16'($urandom);
    end
    we_req = 4'b1111; req = 4'b1111;
    for (int k = 1; k <= 11; k++) begin
      step();
      check("rr_gnt", 32'(gnt), (k % 2 == 1) ? 32'(1 << order[(k - 1) / 2]) : 32'd0);
      if (k < 8)       req = ~gnt;
      else if (k == 8) req = 4'b1001;
      else             req = req & ~gnt;
    end

    // Core1 pulses req for one cycle while core0 is served: ignored.
    step();
    c_addr[0] = 8'($urandom); we_req[0] = 1'b0; req = 4'b0001;
    step();
    check("gl_gnt0", 32'(gnt), 32'h1);
    we_req[1] = 1'b1; req = 4'b0010;
    step();
    req = '0;
    check("gl_gnt_a", 32'(gnt), 32'd0);
    step();
    check("gl_rdv", 32'(rd_valid), 32'h1);
    check("gl_gnt_b", 32'(gnt), 32'd0);
    step();
    check("gl_gnt_c", 32'(gnt), 32'd0);
    step();
    check("gl_gnt_d", 32'(gnt), 32'd0);

    // Reset held across an active command (write, then read).
    for (int op = 1; op >= 0; op--) begin
      c_addr[2] = 8'($urandom); we_req[2] = op[0]; req = 4'b0100;
      step();
      check("rc_gnt", 32'(gnt), 32'h4);
      check("rc_we",  32'(mem_we), 32'(op[0]));
      rst = 1'b1; req = '0;
      step();
      check("rc_we_drop", 32'(mem_we), 32'd0);
      check("rc_busy",    32'(busy), 32'd0);
      rst = 1'b0;
      step();
      check("rc_rdv_a", 32'(rd_valid), 32'd0);
      step();
      check("rc_rdv_b", 32'(rd_valid), 32'd0);
    end

    // Randomized traffic with the protocol-following core agents.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          check("fair", 32'(waits[i] <= 3), 32'd1);
          waits[i] = 0;
          req[i]   = 1'b0;
        end else if (req[i]) begin
          if (gnt != 4'b0) waits[i]++;
        end else if ($urandom_range(0, 2) == 0) begin
          we_req[i] = 1'($urandom_range(0, 1));
          c_addr[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
          c_wd[i]   = 16'($urandom);
          req[i]    = 1'b1;
        end
      end
    end
    req = '0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
